// File: rtl/note_seq_ctrl.sv
// rtl/note_seq_ctrl.sv - programmable note pattern sequencer driving the synth LUT/R2R datapath
module note_seq_ctrl #(
  parameter int STEPS     = 16,
  parameter int ADDR_W    = 4,
  parameter int TEMPO_W   = 24,
  parameter int GAP_TICKS = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [15:0]        wr_data_i,
  input  logic [TEMPO_W-1:0] tempo_i,
  input  logic [ADDR_W-1:0]  len_i,
  input  logic               loop_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic [10:0]        note_sw_o,
  output logic [1:0]         note_oct_o,
  output logic [1:0]         wave_sel_o,
  output logic               gate_o,
  output logic               busy_o,
  output logic [ADDR_W-1:0]  step_idx_o,
  output logic               step_strobe_o,
  output logic               done_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_NOTE   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [TEMPO_W-1:0] MIN_TEMPO = TEMPO_W'(GAP_TICKS + 1);
  localparam logic [TEMPO_W-1:0] ONE      = TEMPO_W'(1);

  logic [15:0]        pat_q [STEPS];
  logic [1:0]         state_q, state_d;
  logic [TEMPO_W-1:0] timer_q, timer_d;
  logic [TEMPO_W-1:0] tempo_q, tempo_d;
  logic [ADDR_W-1:0]  len_q, len_d;
  logic               loop_q, loop_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               strobe_q, strobe_d;
  logic               load;
  logic [15:0]        entry;
  logic [10:0]        sw_q;
  logic [1:0]         oct_q;
  logic [1:0]         wave_q;
  logic               rest_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    tempo_d  = tempo_q;
    len_d    = len_q;
    loop_d   = loop_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          tempo_d  = (tempo_i < MIN_TEMPO) ? MIN_TEMPO : tempo_i;
          len_d    = len_i;
          loop_d   = loop_i;
          state_d  = S_NOTE;
          idx_d    = '0;
          timer_d  = '0;
          strobe_d = 1'b1;
          load     = 1'b1;
        end
      end
      S_NOTE: begin
        timer_d = timer_q + ONE;
        if (timer_q == tempo_q - MIN_TEMPO) state_d = S_GAP;
      end
      S_GAP: begin
        timer_d = timer_q + ONE;
        if (timer_q == tempo_q - ONE) begin
          if (idx_q != len_q || loop_q) begin
            idx_d    = (idx_q != len_q) ? idx_q + 1'b1 : '0;
            state_d  = S_NOTE;
            timer_d  = '0;
            strobe_d = 1'b1;
            load     = 1'b1;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything; note fields and step index keep their last values.
    if (stop_i && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      idx_d    = idx_q;
      strobe_d = 1'b0;
      load     = 1'b0;
    end
  end

  // Nonblocking update means a same-cycle write is not visible to this read.
  assign entry = pat_q[idx_d];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STEPS; i++) pat_q[i] <= 16'h8000;
    end else if (wr_en_i) begin
      pat_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      tempo_q  <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      sw_q     <= '0;
      oct_q    <= '0;
      wave_q   <= '0;
      rest_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tempo_q  <= tempo_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      if (load) begin
        sw_q   <= entry[10:0];
        oct_q  <= entry[12:11];
        wave_q <= (entry[14:13] == 2'd3) ? 2'd2 : entry[14:13];
        rest_q <= entry[15];
      end
    end
  end

  assign note_sw_o     = sw_q;
  assign note_oct_o    = oct_q;
  assign wave_sel_o    = wave_q;
  assign gate_o        = (state_q == S_NOTE) && !rest_q;
  assign busy_o        = (state_q == S_NOTE) || (state_q == S_GAP);
  assign step_idx_o    = idx_q;
  assign step_strobe_o = strobe_q;
  assign done_o        = (state_q == S_FINISH);

endmodule

// File: tb/tb_note_seq_ctrl.sv
// tb/tb_note_seq_ctrl.sv - self-checking bench for note_seq_ctrl against a cycle-count model
module tb_note_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [23:0] tempo = '0;
  logic [3:0]  len = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [10:0] note_sw;
  logic [1:0]  note_oct, wave_sel;
  logic        gate, busy, step_strobe, done;
  logic [3:0]  step_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  note_seq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .tempo_i(tempo), .len_i(len), .loop_i(loop), .start_i(start), .stop_i(stop),
    .note_sw_o(note_sw), .note_oct_o(note_oct), .wave_sel_o(wave_sel), .gate_o(gate),
    .busy_o(busy), .step_idx_o(step_idx), .step_strobe_o(step_strobe), .done_o(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a play is a count of cycles since the first step entry; step and
  // position within the step follow from division by the effective tempo.
  bit          m_act;
  int          m_k, m_T, m_len;
  bit          m_loop;
  logic [15:0] m_pat [16];
  logic [10:0] m_sw;
  logic [1:0]  m_oct, m_wave;
  bit          m_rest;
  logic [3:0]  m_idx;

  function automatic logic [1:0] wave_of(input logic [15:0] p);
    return (p[14:13] == 2'd3) ? 2'd2 : p[14:13];
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int k2, n2, t2, ix;
    if (!rst_n) begin
      m_act <= 0; m_k <= 0; m_T <= 0; m_len <= 0; m_loop <= 0;
      m_sw <= '0; m_oct <= '0; m_wave <= '0; m_rest <= 0; m_idx <= '0;
      for (int i = 0; i < 16; i++) m_pat[i] <= 16'h8000;
    end else begin
      if (m_act && stop) begin
        m_act <= 0;
      end else if (!m_act && start && !stop) begin
        m_act <= 1; m_k <= 0;
        m_T <= (tempo < 3) ? 3 : int'(tempo);
        m_len <= int'(len); m_loop <= loop; m_idx <= '0;
        m_sw <= m_pat[0][10:0]; m_oct <= m_pat[0][12:11];
        m_wave <= wave_of(m_pat[0]); m_rest <= m_pat[0][15];
      end else if (m_act) begin
        k2 = m_k + 1; n2 = k2 / m_T; t2 = k2 % m_T;
        if (!m_loop && n2 > m_len) begin
          if (n2 == m_len + 1 && t2 == 0) m_k <= k2;
          else m_act <= 0;
        end else begin
          m_k <= k2;
          if (t2 == 0) begin
            ix = m_loop ? n2 % (m_len + 1) : n2;
            m_idx <= ix[3:0];
            m_sw <= m_pat[ix][10:0]; m_oct <= m_pat[ix][12:11];
            m_wave <= wave_of(m_pat[ix]); m_rest <= m_pat[ix][15];
          end
        end
      end
      if (wr_en) m_pat[wr_addr] <= wr_data;
    end
  end

  always @(negedge clk) begin : compare
    int n, t;
    bit fin;
    n = (m_T > 0) ? m_k / m_T : 0;
    t = (m_T > 0) ? m_k % m_T : 0;
    fin = m_act && !m_loop && (n == m_len + 1);
    chk("cmp_busy", busy, int'(m_act && !fin));
    chk("cmp_done", done, int'(fin));
    chk("cmp_strobe", step_strobe, int'(m_act && !fin && t == 0));
    chk("cmp_gate", gate, int'(m_act && !fin && t < m_T - 2 && !m_rest));
    chk("cmp_sw", note_sw, m_sw);
    chk("cmp_oct", note_oct, m_oct);
    chk("cmp_wave", wave_sel, m_wave);
    chk("cmp_idx", step_idx, m_idx);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Start is raised in cycle 0; returns positioned in cycle 1.
  task automatic play(input logic [23:0] t, input logic [3:0] l, input logic lp);
    tempo = t; len = l; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] gm, sm, dm, bm;
    gm = 32'h0000_01CE; sm = 32'h0000_0842; dm = 32'h0001_0000; bm = 32'h0000_FFFE;
    tick(); tick();
    chk("rst_gate", gate, 0); chk("rst_busy", busy, 0); chk("rst_sw", note_sw, 0);
    rst_n = 1'b1;
    tick();

    wr(4'd0, 16'h0123); wr(4'd1, 16'h2A45); wr(4'd2, 16'h8000);
    tick();
    play(24'd5, 4'd2, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      chk("t1_gate", gate, int'(gm[c]));
      chk("t1_strobe", step_strobe, int'(sm[c]));
      chk("t1_done", done, int'(dm[c]));
      chk("t1_busy", busy, int'(bm[c]));
      if (c == 3) begin
        chk("t1_sw0", note_sw, 11'h123); chk("t1_oct0", note_oct, 0); chk("t1_wave0", wave_sel, 0);
      end
      if (c == 8) begin
        chk("t1_sw1", note_sw, 11'h245); chk("t1_oct1", note_oct, 1); chk("t1_wave1", wave_sel, 1);
      end
      tick();
    end

    play(24'd5, 4'd2, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      if (c == 15) chk("t2_idx15", step_idx, 2);
      if (c == 16) begin chk("t2_strobe16", step_strobe, 1); chk("t2_idx16", step_idx, 0); end
      if (c == 31) chk("t2_strobe31", step_strobe, 1);
      tick();
    end
    do_stop();
    tick();

    wr(4'd0, 16'h0001);
    play(24'd1, 4'd0, 1'b1);
    chk("t3_gate1", gate, 1); chk("t3_sw", note_sw, 1);
    tick(); chk("t3_gate2", gate, 0);
    tick(); chk("t3_gate3", gate, 0);
    tick(); chk("t3_strobe4", step_strobe, 1); chk("t3_gate4", gate, 1);
    do_stop();
    wr(4'd0, 16'h0123);

    play(24'd5, 4'd2, 1'b0);
    for (int c = 1; c < 7; c++) tick();
    do_stop();
    chk("t4_busy", busy, 0); chk("t4_gate", gate, 0); chk("t4_done", done, 0);
    chk("t4_sw", note_sw, 11'h245); chk("t4_idx", step_idx, 1);
    tick(); tick();
    play(24'd5, 4'd2, 1'b0);
    chk("t4_restart_idx", step_idx, 0); chk("t4_restart_sw", note_sw, 11'h123);
    for (int c = 1; c <= 17; c++) tick();

    play(24'd5, 4'd2, 1'b1);
    for (int c = 1; c < 7; c++) tick();
    wr(4'd1, 16'h4777);
    chk("t5_sw_hold", note_sw, 11'h245); chk("t5_wave_hold", wave_sel, 1);
    for (int c = 8; c < 21; c++) tick();
    chk("t5_sw_new", note_sw, 11'h777); chk("t5_wave_new", wave_sel, 2); chk("t5_oct_new", note_oct, 0);
    do_stop();
    tick();

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t6_busy", busy, 0); chk("t6_strobe", step_strobe, 0);
    tick();

    play(24'd5, 4'd2, 1'b0);
    for (int c = 1; c < 4; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t7_gate", gate, 0); chk("t7_busy", busy, 0); chk("t7_sw", note_sw, 0);
    chk("t7_oct", note_oct, 0); chk("t7_idx", step_idx, 0);
    rst_n = 1'b1;
    tick();
    play(24'd5, 4'd2, 1'b0);
    chk("t7_rest_gate", gate, 0); chk("t7_rest_sw", note_sw, 0); chk("t7_rest_busy", busy, 1);
    for (int c = 1; c <= 17; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
